// File: rtl/cos_arb_pkg.sv
// Shared types and widths for the cosine-engine arbiter.
package cos_arb_pkg;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned RES_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  // Operand pair handed to the engine for one transaction.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } eng_op_t;

endpackage

// File: rtl/cos_arbiter_if.sv
// Requester and engine signals of the cosine arbiter; slave is the arbiter side.
interface cos_arbiter_if
  import cos_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0][X_W-1:0]   x_in;
  logic [NUM_REQ-1:0][Y_W-1:0]   y_in;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [RES_W-1:0]              rsp_data;
  logic                          rsp_err;
  logic                          busy;
  logic                          eng_start;
  logic [X_W-1:0]                eng_x;
  logic [Y_W-1:0]                eng_y;
  logic                          eng_done;
  logic [RES_W-1:0]              eng_result;

  modport slave (
    input  req, x_in, y_in, eng_done, eng_result,
    output rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_x, eng_y
  );

  modport master (
    output req, x_in, y_in, eng_done, eng_result,
    input  rsp_valid, rsp_data, rsp_err, busy, eng_start, eng_x, eng_y
  );

endinterface

// File: rtl/cos_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping.
module cos_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  int pos;

  // Scan from the farthest offset down so the nearest set bit wins.
  always_comb begin
    gnt_idx = '0;
    gnt_any = |req;
    pos     = 0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      pos = int'(rr_ptr) + i;
      if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
      if (req[IDX_W'(pos)]) gnt_idx = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/cos_arbiter.sv
// Round-robin arbiter sharing one cosine engine among NUM_REQ requesters,
// with a stale-done mask on the first WAIT cycle and a WAIT timeout.
module cos_arbiter
  import cos_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  cos_arbiter_if.slave    bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  eng_op_t             op_q, op_d;
  logic                eng_start_q, eng_start_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                done_ok;
  logic                expired;

  cos_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // First WAIT cycle (cnt_q == 0) ignores a done level left over from before.
  assign done_ok = bus.eng_done && (cnt_q != '0);
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      eng_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      eng_start_q <= eng_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    eng_start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d     = pick_idx;
          op_d.x      = bus.x_in[pick_idx];
          op_d.y      = bus.y_in[pick_idx];
          eng_start_d = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Done is checked before expiry so a coincident done wins.
        if (done_ok) begin
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_data_d  = bus.eng_result;
          state_d     = RESP;
        end else if (expired) begin
          rsp_valid_d = NUM_REQ'(1) << grant_q;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        op_d     = '0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.eng_start = eng_start_q;
  assign bus.eng_x     = op_q.x;
  assign bus.eng_y     = op_q.y;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cos_arbiter.sv
// Randomized scoreboard bench for cos_arbiter against a cycle-level transaction model.
module tb_cos_arbiter;
  import cos_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 255;
  localparam int M_DONE = 0, M_HELD = 1, M_TIMEOUT = 2, M_EDGE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   ptr_m = 0;

  typedef struct { int cyc; int idx; logic [RES_W-1:0] data; logic err; } rsp_exp_t;
  typedef struct { int cyc; logic [X_W-1:0] x; logic [Y_W-1:0] y; } start_exp_t;

  rsp_exp_t   rsp_q[$];
  start_exp_t start_q[$];
  rsp_exp_t   mon_r;
  start_exp_t mon_s;

  cos_arbiter_if #(.NUM_REQ(NR)) bus ();

  cos_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first requesting index at or after the pointer, wrapping.
  function automatic int pick(input logic [NR-1:0] r, input int p);
    logic [NR-1:0] sh;
    for (int off = 0; off < int'(NR); off++) begin
      sh = r >> ((p + off) % int'(NR));
      if (sh[0]) return (p + off) % int'(NR);
    end
    return -1;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a start or a response.
  always @(negedge clk) begin
    if (bus.eng_start) begin
      check("start_expected", 32'(start_q.size() != 0), 32'd1);
      if (start_q.size() != 0) begin
        mon_s = start_q.pop_front();
        check("start_cycle", 32'(cyc), 32'(mon_s.cyc));
        check("start_eng_x", 32'(bus.eng_x), 32'(mon_s.x));
        check("start_eng_y", 32'(bus.eng_y), 32'(mon_s.y));
        check("start_busy", 32'(bus.busy), 32'd1);
      end
    end
    if (bus.rsp_valid != '0) begin
      check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        mon_r = rsp_q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
        check("rsp_valid_onehot", 32'(bus.rsp_valid), 32'(1) << mon_r.idx);
        check("rsp_data", 32'(bus.rsp_data), 32'(mon_r.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(mon_r.err));
        check("rsp_busy", 32'(bus.busy), 32'd1);
      end
    end
  end

  // One transaction; entered at a negedge in IDLE, returns at the negedge after RESP.
  task automatic run_txn(input logic [NR-1:0] r, input logic [X_W-1:0] x0, input logic [Y_W-1:0] y0,
                         input int mode, input int w, input logic [RES_W-1:0] res,
                         input bit stale, input bit drop);
    int g, c0, acc_w, wlen, rc, wi;
    bit accepted;
    rsp_exp_t   er;
    start_exp_t es;
    c0 = cyc;
    g  = pick(r, ptr_m);
    case (mode)
      M_HELD:  acc_w = 1;
      M_EDGE:  acc_w = int'(TO) - 1;
      M_DONE:  acc_w = w;
      default: acc_w = 0;
    endcase
    accepted = (mode != M_TIMEOUT);
    wlen = accepted ? acc_w + 1 : int'(TO);
    rc   = c0 + 2 + wlen;
    es.cyc = c0 + 1; es.x = x0; es.y = y0;
    start_q.push_back(es);
    er.cyc = rc; er.idx = g; er.data = accepted ? res : '0; er.err = !accepted;
    rsp_q.push_back(er);
    ptr_m = (g + 1) % int'(NR);

    for (int i = 0; i < int'(NR); i++) begin
      bus.x_in[IW'(i)] = (i == g) ? x0 : X_W'($urandom);
      bus.y_in[IW'(i)] = (i == g) ? y0 : Y_W'($urandom);
    end
    bus.req        = r;
    bus.eng_done   = (mode == M_HELD);
    bus.eng_result = RES_W'($urandom);

    for (int n = c0 + 1; n <= rc; n++) begin
      @(negedge clk);
      wi = n - (c0 + 2);
      for (int i = 0; i < int'(NR); i++) begin
        bus.x_in[IW'(i)] = X_W'($urandom);
        bus.y_in[IW'(i)] = Y_W'($urandom);
      end
      if (drop) bus.req[IW'(g)] = 1'b0;
      if (n == rc - 1) begin
        check("wait_eng_x", 32'(bus.eng_x), 32'(x0));
        check("wait_eng_y", 32'(bus.eng_y), 32'(y0));
      end
      if (n < rc) begin
        bus.eng_done   = (mode == M_HELD) || (accepted && wi == acc_w) || (stale && wi == 0);
        bus.eng_result = (accepted && wi == acc_w) ? res : RES_W'($urandom);
      end
    end
    bus.req      = '0;
    bus.eng_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.req = '0;
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_eng_start", 32'(bus.eng_start), 32'd0);
      check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  // Grant requester 2, then pull reset in the middle of WAIT.
  task automatic run_abort();
    int g;
    start_exp_t es;
    g = pick(NR'(4'b0100), ptr_m);
    for (int i = 0; i < int'(NR); i++) begin
      bus.x_in[IW'(i)] = X_W'($urandom);
      bus.y_in[IW'(i)] = Y_W'($urandom);
    end
    es.cyc = cyc + 1; es.x = bus.x_in[IW'(g)]; es.y = bus.y_in[IW'(g)];
    start_q.push_back(es);
    bus.req = NR'(4'b0100);
    bus.eng_done = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_eng_start", 32'(bus.eng_start), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_eng_x", 32'(bus.eng_x), 32'd0);
    check("abort_eng_y", 32'(bus.eng_y), 32'd0);
    ptr_m = 0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int m, md;
    bus.req        = '0;
    bus.x_in       = '0;
    bus.y_in       = '0;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_eng_start", 32'(bus.eng_start), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_eng_x", 32'(bus.eng_x), 32'd0);
    check("reset_eng_y", 32'(bus.eng_y), 32'd0);
    rst = 1'b1;

    // All four requesting, engine done three cycles after each start.
    for (int k = 0; k < 5; k++)
      run_txn(NR'(4'b1111), X_W'($urandom), Y_W'($urandom), M_DONE, 2, RES_W'($urandom), 1'b0, 1'b0);
    run_txn(NR'(4'b0001), 10'h080, 8'h40, M_DONE, 3, 10'h1F0, 1'b0, 1'b0);
    run_txn(NR'(4'b0010), X_W'($urandom), Y_W'($urandom), M_HELD, 0, RES_W'($urandom), 1'b0, 1'b0);
    run_txn(NR'(4'b1111), X_W'($urandom), Y_W'($urandom), M_TIMEOUT, 0, RES_W'($urandom), 1'b0, 1'b0);
    run_txn(NR'(4'b1111), X_W'($urandom), Y_W'($urandom), M_DONE, 1, RES_W'($urandom), 1'b0, 1'b0);
    run_txn(NR'(4'b0100), X_W'($urandom), Y_W'($urandom), M_EDGE, 0, RES_W'($urandom), 1'b0, 1'b0);
    run_txn(NR'(4'b1000), X_W'($urandom), Y_W'($urandom), M_DONE, 2, RES_W'($urandom), 1'b1, 1'b1);
    idle(3);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(3) == 0) idle(int'($urandom_range(3, 1)));
      m = int'($urandom_range(19));
      md = (m == 0) ? M_TIMEOUT : (m == 1) ? M_HELD : (m == 2) ? M_EDGE : M_DONE;
      run_txn(NR'($urandom_range(15, 1)), X_W'($urandom), Y_W'($urandom), md,
              int'($urandom_range(6, 1)), RES_W'($urandom), 1'($urandom), 1'($urandom));
    end

    run_abort();
    run_txn(NR'(4'b0110), X_W'($urandom), Y_W'($urandom), M_DONE, 1, RES_W'($urandom), 1'b0, 1'b0);
    idle(2);
    check("start_queue_drained", 32'(start_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cos_arbiter.md
COS_ARBITER -- requirements
Module: cos_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one cosine engine.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before the engine result is abandoned.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  NUM_REQ  per-requester request level, held until that requester's rsp_valid.
REQ-006 The block SHALL have port x_in  input  NUM_REQ x 10  per-requester x operand.
REQ-007 The block SHALL have port y_in  input  NUM_REQ x 8  per-requester y operand.
REQ-008 The block SHALL have port rsp_valid  output  NUM_REQ  one-hot, one-cycle response pulse.
REQ-009 The block SHALL have port rsp_data  output  10  result {int_part[1:0], frac_part[7:0]}, valid with rsp_valid.
REQ-010 The block SHALL have port rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 The block SHALL have port eng_start  output  1  one-cycle start pulse to the cosine engine.
REQ-013 The block SHALL have ports eng_x  output  10  and eng_y  output  8  carrying the granted operands, held stable from LAUNCH through WAIT.
REQ-014 The block SHALL have port eng_done  input  1  engine completion level.
REQ-015 The block SHALL have port eng_result  input  10  engine result {int_part, frac_part}.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT, RESP.
REQ-017 In IDLE with any req bit high, the block SHALL grant the first high bit at or after rr_ptr (wrapping modulo NUM_REQ), latch its index, x_in and y_in, and enter LAUNCH on the next edge.
REQ-018 In IDLE with req all zero, the block SHALL remain in IDLE with all outputs at reset values.
REQ-019 LAUNCH SHALL last exactly one cycle with eng_start=1, then enter WAIT.
REQ-020 In WAIT, the block SHALL ignore eng_done in the first WAIT cycle, to mask a stale done level; on any later cycle with eng_done=1 it SHALL capture eng_result and enter RESP.
REQ-021 A WAIT cycle counter SHALL count from 0; if it reaches TIMEOUT without accepted done, the block SHALL enter RESP with rsp_err=1 and rsp_data=0.
REQ-022 RESP SHALL last one cycle, driving rsp_valid[grant]=1, rsp_data and rsp_err.
REQ-023 On leaving RESP, the block SHALL set rr_ptr=(grant+1) mod NUM_REQ and SHALL return to IDLE; a new grant SHALL therefore start no earlier than the cycle after RESP.
REQ-024 Latency SHALL be: req seen in IDLE at cycle 0, eng_start at cycle 1, done accepted at cycle k>=3, rsp_valid at cycle k+1.
REQ-025 If the granted requester drops req after grant, the block SHALL still complete the transaction and pulse rsp_valid.
REQ-026 Operand changes on x_in/y_in after the grant SHALL NOT affect eng_x/eng_y.
REQ-027 If eng_done rises in the same cycle as timeout expiry, the done SHALL win and rsp_err SHALL be 0.

Reset
REQ-028 Asserting rst low at any time, including mid-WAIT, SHALL immediately force state=IDLE, rr_ptr=0, grant=0, counter=0, eng_start=0, eng_x=0, eng_y=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0.
REQ-029 After rst deasserts, the first grant SHALL be evaluated on the first rising clk edge.

Structure
REQ-030 A shared package cos_arb_pkg SHALL hold the state enum, X_W=10, Y_W=8, and RES_W=10.
REQ-031 Round-robin selection SHALL be a sub-module cos_rr_pick (inputs req, rr_ptr; outputs gnt_idx, gnt_any), purely combinational.

Verification
REQ-032 Bench: req=0001, x_in[0]=10'h080, y_in[0]=8'h40, eng_done at cycle 5 with eng_result=10'h1F0 -> eng_start at cycle 1, rsp_valid=0001 at cycle 6, rsp_data=10'h1F0, rsp_err=0.
REQ-033 Bench: req=1111 held, engine done 3 cycles after each start -> grants in order 0,1,2,3,0, with exactly one rsp_valid bit per RESP.
REQ-034 Bench: eng_done held at 1 continuously -> first WAIT cycle ignored, rsp_valid at LAUNCH+3.
REQ-035 Bench: eng_done never asserted, TIMEOUT=255 -> rsp_err=1 and rsp_data=0 after 255 WAIT cycles, then the next requester is granted.
REQ-036 Bench: rst low mid-WAIT with req=0100 -> busy=0 and eng_start=0 immediately; after release with req=0110, requester 1 is granted (rr_ptr=0).
REQ-037 Bench: done and timeout in the same cycle -> rsp_err=0 and rsp_data=eng_result.
